// File: rtl/comple_adder_cc_seq.sv
`default_nettype none
// ============================================================================
// Module      : comple_adder_cc_seq
// Description : Multi-cycle complement adder/subtractor with Z/V/C/N condition
//               codes, one SLICE-bit slice per clock, LSB slice first.
//               Optional macro CC_COMPARE_EN adds the compare-only cmp input.
// Revision    : 1.0 - initial release
// ============================================================================
module comple_adder_cc_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef CC_COMPARE_EN
    input  logic             cmp,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             N
);

    localparam int              c_NS   = WIDTH / SLICE;
    localparam int              c_CW   = (c_NS > 1) ? $clog2(c_NS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bx;
    logic [WIDTH-1:0] r_shadow;
    logic             r_carry;
    logic             r_zacc;
    logic             r_cmp_only;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_slice_sum;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_msb_cin;
    logic             w_zero;
    logic             w_last;
    logic             w_cmp_req;
    logic [WIDTH-1:0] w_next_shadow;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    assign w_a_sl      = r_a[SLICE-1:0];
    assign w_b_sl      = r_bx[SLICE-1:0];
    assign w_slice_sum = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_sum       = w_slice_sum[SLICE-1:0];
    assign w_cout      = w_slice_sum[SLICE];
    // Carry into the top bit recovered from the sum bit, valid for any SLICE >= 1
    assign w_msb_cin   = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1];
    assign w_zero      = r_zacc & ~(|w_sum);
    assign w_last      = (r_cnt == c_LAST);

`ifdef CC_COMPARE_EN
    assign w_cmp_req = cmp & op[1];
`else
    assign w_cmp_req = 1'b0;
`endif

    generate
        if (c_NS == 1) begin : g_single
            assign w_next_shadow = w_sum;
            assign w_a_next      = r_a;
            assign w_b_next      = r_bx;
        end else begin : g_multi
            assign w_next_shadow = {w_sum, r_shadow[WIDTH-1:SLICE]};
            assign w_a_next      = {{SLICE{1'b0}}, r_a[WIDTH-1:SLICE]};
            assign w_b_next      = {{SLICE{1'b0}}, r_bx[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_bx       <= '0;
            r_shadow   <= '0;
            r_carry    <= 1'b0;
            r_zacc     <= 1'b0;
            r_cmp_only <= 1'b0;
            Y          <= '0;
            Z          <= 1'b0;
            V          <= 1'b0;
            C          <= 1'b0;
            N          <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a        <= A;
                        r_bx       <= op[1] ? ~B : B;
                        // ADD:0, ADC:C, SUB:1, SBB:C
                        r_carry    <= op[0] ? C : op[1];
                        r_zacc     <= 1'b1;
                        r_cnt      <= '0;
                        r_cmp_only <= w_cmp_req;
                    end
                end
                c_RUN: begin
                    r_a      <= w_a_next;
                    r_bx     <= w_b_next;
                    r_carry  <= w_cout;
                    r_zacc   <= w_zero;
                    r_shadow <= w_next_shadow;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (!r_cmp_only) begin
                            Y <= w_next_shadow;
                        end
                        Z <= w_zero;
                        V <= w_msb_cin ^ w_cout;
                        C <= w_cout;
                        N <= w_sum[SLICE-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comple_adder_cc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_comple_adder_cc_seq
// Description : Self-checking bench for comple_adder_cc_seq (WIDTH=16, SLICE=4)
//               with a whole-word arithmetic model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comple_adder_cc_seq;

    localparam int NS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] A;
    logic [15:0] B;
`ifdef CC_COMPARE_EN
    logic        cmp;
`endif
    logic        busy;
    logic        done;
    logic [15:0] Y;
    logic        Z;
    logic        V;
    logic        C;
    logic        N;

    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] exp_Y    = 16'h0;
    logic        exp_Z    = 1'b0;
    logic        exp_V    = 1'b0;
    logic        exp_C    = 1'b0;
    logic        exp_N    = 1'b0;

    comple_adder_cc_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
`ifdef CC_COMPARE_EN
        .cmp   (cmp),
`endif
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .Z     (Z),
        .V     (V),
        .C     (C),
        .N     (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Cycle-by-cycle comparison against the model's expected outputs
    always @(posedge clk) begin
        #2;
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("done", {31'b0, done}, {31'b0, exp_done});
        chk("Y", {16'b0, Y}, {16'b0, exp_Y});
        chk("ZVCN", {28'b0, Z, V, C, N}, {28'b0, exp_Z, exp_V, exp_C, exp_N});
    end

    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic cm, input logic glitch);
        logic        cin;
        logic [15:0] bx;
        logic [16:0] full;
        logic [15:0] ny;
        logic        nv;
        logic        keep_y;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
`ifdef CC_COMPARE_EN
        cmp   = cm;
`endif
        cin    = (o == 2'b00) ? 1'b0 : (o == 2'b10) ? 1'b1 : exp_C;
        bx     = o[1] ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {16'b0, cin};
        ny     = full[15:0];
        nv     = (a[15] == bx[15]) && (ny[15] != a[15]);
`ifdef CC_COMPARE_EN
        keep_y = cm && o[1];
`else
        keep_y = 1'b0;
        if (cm) keep_y = 1'b0;
`endif
        @(posedge clk);
        exp_busy = 1'b1;
        for (int i = 1; i <= NS + 1; i++) begin
            @(negedge clk);
            start = glitch && (i == 1 || i == NS + 1);
            A     = 16'($urandom);
            B     = 16'($urandom);
            op    = 2'($urandom);
            @(posedge clk);
            if (i == NS) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                if (!keep_y) exp_Y = ny;
                exp_Z = (ny == 16'h0);
                exp_V = nv;
                exp_C = full[16];
                exp_N = ny[15];
            end
            if (i == NS + 1) exp_done = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
`ifdef CC_COMPARE_EN
        cmp   = 1'b0;
`endif
    endtask

    task automatic pin(input string name, input logic [15:0] y, input logic [3:0] zvcn);
        chk({name, "_Y"}, {16'b0, Y}, {16'b0, y});
        chk({name, "_flags"}, {28'b0, Z, V, C, N}, {28'b0, zvcn});
        chk({name, "_model"}, {12'b0, exp_Y, exp_Z, exp_V, exp_C, exp_N}, {12'b0, y, zvcn});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 16'h0;
        B     = 16'h0;
`ifdef CC_COMPARE_EN
        cmp   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'b00, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("add",      16'h3579, 4'b0000);
        do_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0); pin("add_wrap", 16'h0000, 4'b1010);
        do_op(2'b01, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("adc",      16'h357A, 4'b0000);
        do_op(2'b10, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("sub",      16'hEEEF, 4'b0001);
        do_op(2'b11, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("sbb_c0",   16'hEEEE, 4'b0001);
        do_op(2'b10, 16'h2345, 16'h1234, 1'b0, 1'b0); pin("sub_pos",  16'h1111, 4'b0010);
        do_op(2'b11, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("sbb_c1",   16'hEEEF, 4'b0001);
        do_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0); pin("add_ovf",  16'h8000, 4'b0101);
        do_op(2'b10, 16'h8000, 16'h0001, 1'b0, 1'b0); pin("sub_ovf",  16'h7FFF, 4'b0110);
        do_op(2'b00, 16'h1111, 16'h2222, 1'b0, 1'b1); pin("glitch",   16'h3333, 4'b0000);

        // Abort mid-RUN with an asynchronous reset
        start = 1'b1; op = 2'b00; A = 16'hFFFF; B = 16'hFFFF;
        @(posedge clk);
        exp_busy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_Y", {16'b0, Y}, 32'd0);
        chk("abort_flags", {28'b0, Z, V, C, N}, 32'd0);
        exp_busy = 1'b0; exp_done = 1'b0; exp_Y = 16'h0;
        exp_Z = 1'b0; exp_V = 1'b0; exp_C = 1'b0; exp_N = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NS + 3) @(negedge clk);

        do_op(2'b00, 16'h0001, 16'h0001, 1'b0, 1'b0); pin("post_rst", 16'h0002, 4'b0000);

`ifdef CC_COMPARE_EN
        do_op(2'b00, 16'h1234, 16'h2345, 1'b0, 1'b0); pin("pre_cmp",  16'h3579, 4'b0000);
        do_op(2'b10, 16'h2345, 16'h2345, 1'b1, 1'b0); pin("cmp_sub",  16'h3579, 4'b1010);
        do_op(2'b00, 16'h0001, 16'h0002, 1'b1, 1'b0); pin("cmp_add",  16'h0003, 4'b0000);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
